// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised single-clock FIFO with thresholds, count, FWFT mode, flush and error pulses
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        synchronous clear of pointers/count/status; overrides push and pop
//   push         write request, data_in stored when accepted
//   data_in      write data
//   pop          read request
//   data_out     read data (registered in FWFT=0, fall-through in FWFT=1)
//   data_valid   FWFT=0: one-cycle pulse after an accepted pop; FWFT=1: !empty
//   count        occupancy 0..DEPTH
//   full, empty  count == DEPTH, count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   overflow     one-cycle pulse after a rejected push
//   underflow    one-cycle pulse after a rejected pop
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // All status flags decode the registered count only, so push/pop never
    // reach a flag combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A push into a full FIFO is still taken when a pop frees the slot in
    // the same cycle; a pop from an empty FIFO is never bypassed.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            overflow  <= push & ~push_ok;
            underflow <= pop & ~pop_ok;
        end
    end

    // Storage is not reset or flushed; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_out   <= '0;
                    data_valid <= 1'b0;
                end else if (flush) begin
                    // data_out deliberately keeps the last word read
                    data_valid <= 1'b0;
                end else begin
                    data_valid <= pop_ok;
                    if (pop_ok) begin
                        data_out <= mem[rd_ptr];
                    end
                end
            end
        end else begin : g_fall_through
            // Forced to zero while empty so stale storage never shows and the
            // output is zero straight out of reset.
            assign data_out   = empty ? '0 : mem[rd_ptr];
            assign data_valid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - self-checking bench for fifo_flex in both read modes
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] d0_out, d1_out;
    logic       d0_valid, d1_valid;
    logic [3:0] c0, c1;
    logic       f0, e0, af0, ae0, ov0, un0;
    logic       f1, e1, af1, ae1, ov1, un1;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model: queue of stored words plus the registered-read outputs
    logic [7:0] q[$];
    logic [7:0] m_dout0 = '0;
    bit         m_dv0 = 0, m_ov = 0, m_un = 0;

    always #5 clk = ~clk;

    fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(d0_out), .data_valid(d0_valid), .count(c0), .full(f0), .empty(e0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ov0), .underflow(un0));

    fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
        .data_out(d1_out), .data_valid(d1_valid), .count(c1), .full(f1), .empty(e1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ov1), .underflow(un1));

    // one clock of stimulus; model advances from the pre-edge state
    task automatic cycle(input bit f, input bit pu, input bit po, input logic [7:0] d);
        bit m_full, m_empty, p_ok, w_ok;
        m_full  = (q.size() == 8);
        m_empty = (q.size() == 0);
        p_ok    = po && !m_empty;
        w_ok    = pu && (!m_full || p_ok);
        flush = f; push = pu; pop = po; data_in = d;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
            m_dv0 = 0; m_ov = 0; m_un = 0;
        end else begin
            if (p_ok) m_dout0 = q.pop_front();
            if (w_ok) q.push_back(d);
            m_dv0 = p_ok;
            m_ov  = pu && !w_ok;
            m_un  = po && !p_ok;
        end
        flush = 0; push = 0; pop = 0;
    endtask

    task automatic test_reset;
        tests_run++; if (c0 !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d expected 0", c0); end
        tests_run++; if (e0 !== 1'b1 || f0 !== 1'b0) begin tests_failed++; $display("FAIL reset_full_empty got full=%b empty=%b expected 0/1", f0, e0); end
        tests_run++; if (af0 !== 1'b0 || ae0 !== 1'b1) begin tests_failed++; $display("FAIL reset_almost got af=%b ae=%b expected 0/1", af0, ae0); end
        tests_run++; if (d0_out !== 8'h00 || d0_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dout got %h/%b expected 00/0", d0_out, d0_valid); end
        tests_run++; if (ov0 !== 1'b0 || un0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err got ov=%b un=%b expected 0/0", ov0, un0); end
        tests_run++; if (d1_out !== 8'h00 || d1_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fwft got %h/%b expected 00/0", d1_out, d1_valid); end
    endtask

    task automatic test_reset_mid_fill;
        cycle(0, 1, 0, 8'h01);
        cycle(0, 1, 0, 8'h02);
        cycle(0, 1, 0, 8'h03);
        tests_run++; if (c0 !== 4'd3) begin tests_failed++; $display("FAIL midfill_count got %0d expected 3", c0); end
        rst = 0;
        #2;
        tests_run++; if (c0 !== 4'd0 || e0 !== 1'b1 || ae0 !== 1'b1) begin tests_failed++; $display("FAIL midfill_async got count=%0d empty=%b ae=%b expected 0/1/1", c0, e0, ae0); end
        tests_run++; if (d0_out !== 8'h00) begin tests_failed++; $display("FAIL midfill_dout got %h expected 00", d0_out); end
        #2;
        rst = 1;
        q.delete(); m_dout0 = '0; m_dv0 = 0; m_ov = 0; m_un = 0;
        cycle(0, 1, 0, 8'h77);
        cycle(0, 0, 1, 8'h00);
        tests_run++; if (d0_out !== 8'h77 || d0_valid !== 1'b1 || c0 !== 4'd0) begin tests_failed++; $display("FAIL midfill_fresh got %h/%b count=%0d expected 77/1/0", d0_out, d0_valid, c0); end
    endtask

    task automatic test_fill_overflow;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 8'h10 + 8'(i));
            tests_run++; if (af0 !== ((i + 1) >= 6)) begin tests_failed++; $display("FAIL fill_af[%0d] got %b expected %b", i, af0, (i + 1) >= 6); end
        end
        tests_run++; if (f0 !== 1'b1 || c0 !== 4'd8) begin tests_failed++; $display("FAIL fill_full got full=%b count=%0d expected 1/8", f0, c0); end
        cycle(0, 1, 0, 8'h99);
        tests_run++; if (ov0 !== 1'b1 || c0 !== 4'd8) begin tests_failed++; $display("FAIL overflow got ov=%b count=%0d expected 1/8", ov0, c0); end
        cycle(0, 0, 0, 8'h00);
        tests_run++; if (ov0 !== 1'b0) begin tests_failed++; $display("FAIL overflow_pulse got %b expected 0", ov0); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (d1_out !== 8'h10 + 8'(i)) begin tests_failed++; $display("FAIL drain_fwft[%0d] got %h expected %h", i, d1_out, 8'h10 + 8'(i)); end
            cycle(0, 0, 1, 8'h00);
            tests_run++; if (d0_out !== 8'h10 + 8'(i) || d0_valid !== 1'b1) begin tests_failed++; $display("FAIL drain[%0d] got %h/%b expected %h/1", i, d0_out, d0_valid, 8'h10 + 8'(i)); end
        end
        cycle(0, 0, 1, 8'h00);
        tests_run++; if (un0 !== 1'b1 || d0_out !== 8'h17 || d0_valid !== 1'b0) begin tests_failed++; $display("FAIL underflow got un=%b dout=%h dv=%b expected 1/17/0", un0, d0_out, d0_valid); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h10 + 8'(i));
        cycle(0, 1, 1, 8'hAA);
        tests_run++; if (c0 !== 4'd8 || d0_out !== 8'h10 || ov0 !== 1'b0) begin tests_failed++; $display("FAIL wrap_both got count=%0d dout=%h ov=%b expected 8/10/0", c0, d0_out, ov0); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_d;
            exp_d = (i < 7) ? 8'h11 + 8'(i) : 8'hAA;
            cycle(0, 0, 1, 8'h00);
            tests_run++; if (d0_out !== exp_d) begin tests_failed++; $display("FAIL wrap_pop[%0d] got %h expected %h", i, d0_out, exp_d); end
        end
        tests_run++; if (e0 !== 1'b1) begin tests_failed++; $display("FAIL wrap_empty got %b expected 1", e0); end
    endtask

    task automatic test_fwft;
        cycle(0, 1, 0, 8'h5C);
        tests_run++; if (d1_out !== 8'h5C || d1_valid !== 1'b1) begin tests_failed++; $display("FAIL fwft_show got %h/%b expected 5c/1", d1_out, d1_valid); end
        cycle(0, 0, 1, 8'h00);
        tests_run++; if (e1 !== 1'b1 || d1_valid !== 1'b0) begin tests_failed++; $display("FAIL fwft_pop got empty=%b dv=%b expected 1/0", e1, d1_valid); end
        cycle(0, 1, 1, 8'h6D);
        tests_run++; if (un1 !== 1'b1 || c1 !== 4'd1 || d1_out !== 8'h6D) begin tests_failed++; $display("FAIL fwft_empty_both got un=%b count=%0d dout=%h expected 1/1/6d", un1, c1, d1_out); end
        cycle(0, 0, 1, 8'h00);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h40 + 8'(i));
        tests_run++; if (c0 !== 4'd5) begin tests_failed++; $display("FAIL flush_pre got %0d expected 5", c0); end
        cycle(1, 1, 1, 8'hEE);
        tests_run++; if (c0 !== 4'd0 || e0 !== 1'b1 || ov0 !== 1'b0 || un0 !== 1'b0 || d0_valid !== 1'b0) begin tests_failed++; $display("FAIL flush got count=%0d empty=%b ov=%b un=%b dv=%b expected 0/1/0/0/0", c0, e0, ov0, un0, d0_valid); end
        cycle(0, 1, 0, 8'h33);
        cycle(0, 0, 1, 8'h00);
        tests_run++; if (d0_out !== 8'h33 || c0 !== 4'd0) begin tests_failed++; $display("FAIL flush_after got %h count=%0d expected 33/0", d0_out, c0); end
    endtask

    task automatic test_random;
        for (int n = 0; n < 400; n++) begin
            bit f, pu, po;
            f  = ($urandom_range(0, 39) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 50);
            cycle(f, pu, po, 8'($urandom));
            tests_run++;
            if (c0 !== 4'(q.size()) || c1 !== 4'(q.size())) begin tests_failed++; $display("FAIL rnd_count[%0d] got %0d/%0d expected %0d", n, c0, c1, q.size()); end
            tests_run++;
            if (f0 !== (q.size() == 8) || e0 !== (q.size() == 0) || af0 !== (q.size() >= 6) || ae0 !== (q.size() <= 1)) begin
                tests_failed++; $display("FAIL rnd_flags[%0d] got f=%b e=%b af=%b ae=%b for count %0d", n, f0, e0, af0, ae0, q.size());
            end
            tests_run++;
            if (ov0 !== m_ov || un0 !== m_un || ov1 !== m_ov || un1 !== m_un) begin tests_failed++; $display("FAIL rnd_err[%0d] got ov=%b un=%b expected %b/%b", n, ov0, un0, m_ov, m_un); end
            tests_run++;
            if (d0_valid !== m_dv0 || d0_out !== m_dout0) begin tests_failed++; $display("FAIL rnd_reg[%0d] got %h/%b expected %h/%b", n, d0_out, d0_valid, m_dout0, m_dv0); end
            tests_run++;
            if (d1_valid !== (q.size() != 0) || (q.size() != 0 && d1_out !== q[0])) begin
                tests_failed++; $display("FAIL rnd_fwft[%0d] got %h/%b expected %h/%b", n, d1_out, d1_valid, (q.size() != 0) ? q[0] : 8'h00, q.size() != 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        #4;
        rst = 1;
        test_reset_mid_fill;
        test_fill_overflow;
        test_drain;
        test_wrap;
        test_fwft;
        test_flush;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
